// File: rtl/regfile_scoreboard.sv
// Parametrised register file with combinational read ports, optional write-to-read
// bypass and a per-register busy scoreboard for decode hazard detection.
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int IDXW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREAD*IDXW-1:0] rd_idx,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [IDXW-1:0]       wr_idx,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  issue_en,
  input  logic [IDXW-1:0]       issue_idx,
  output logic [NREGS-1:0]      busy_vec
);

  localparam logic [IDXW:0] NREGS_L = NREGS[IDXW:0];

  logic [XLEN-1:0]  gp [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;
  logic             iss_ok;
  logic [IDXW-1:0]  ridx;

  // Out-of-range indices and the hard-wired zero register are never stored or tracked.
  function automatic logic idx_valid(input logic [IDXW-1:0] idx);
    return ({1'b0, idx} < NREGS_L) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  assign wr_ok    = wr_en && idx_valid(wr_idx);
  assign iss_ok   = issue_en && idx_valid(issue_idx);
  assign busy_vec = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        gp[i] <= '0;
      end
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_ok && (wr_idx == i[IDXW-1:0])) begin
          gp[i] <= wr_data;
        end
        // A new producer issued in the same cycle as the old one retires keeps the bit set.
        if (iss_ok && (issue_idx == i[IDXW-1:0])) begin
          busy[i] <= 1'b1;
        end else if (wr_ok && (wr_idx == i[IDXW-1:0])) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ridx    = '0;
    for (int p = 0; p < NREAD; p++) begin
      ridx = rd_idx[p*IDXW +: IDXW];
      if (idx_valid(ridx)) begin
        // Forwarded data is final, so the reader need not stall on it.
        if ((BYPASS != 0) && wr_ok && (wr_idx == ridx)) begin
          rd_data[p*XLEN +: XLEN] = wr_data;
        end else begin
          rd_data[p*XLEN +: XLEN] = gp[ridx];
          rd_busy[p]              = busy[ridx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and non-bypass instances on shared stimulus,
// plus a wide 24-entry, 3-port instance for bounds and parameter checks.
module tb_regfile_scoreboard;

  localparam int XA = 32, NA = 32, RA = 2, IA = 5;
  localparam int XC = 64, NC = 24, RC = 3, IC = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [RA*IA-1:0] rd_idx;
  logic             wr_en, issue_en;
  logic [IA-1:0]    wr_idx, issue_idx;
  logic [XA-1:0]    wr_data;
  logic [RA*XA-1:0] rd_data_a, rd_data_b;
  logic [RA-1:0]    rd_busy_a, rd_busy_b;
  logic [NA-1:0]    busy_vec_a, busy_vec_b;

  logic [RC*IC-1:0] rd_idx_c;
  logic             wr_en_c, issue_en_c;
  logic [IC-1:0]    wr_idx_c, issue_idx_c;
  logic [XC-1:0]    wr_data_c;
  logic [RC*XC-1:0] rd_data_c;
  logic [RC-1:0]    rd_busy_c;
  logic [NC-1:0]    busy_vec_c;

  regfile_scoreboard #(.XLEN(XA), .NREGS(NA), .NREAD(RA), .BYPASS(1), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .issue_en(issue_en),
    .issue_idx(issue_idx), .busy_vec(busy_vec_a));

  regfile_scoreboard #(.XLEN(XA), .NREGS(NA), .NREAD(RA), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .issue_en(issue_en),
    .issue_idx(issue_idx), .busy_vec(busy_vec_b));

  regfile_scoreboard #(.XLEN(XC), .NREGS(NC), .NREAD(RC), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_idx(rd_idx_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en(wr_en_c), .wr_idx(wr_idx_c), .wr_data(wr_data_c), .issue_en(issue_en_c),
    .issue_idx(issue_idx_c), .busy_vec(busy_vec_c));

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [63:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", obs, ~obs);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic drive_a(input logic we, input logic [IA-1:0] wi, input logic [XA-1:0] wd,
                         input logic ie, input logic [IA-1:0] ii,
                         input logic [IA-1:0] r0, input logic [IA-1:0] r1);
    wr_en = we; wr_idx = wi; wr_data = wd; issue_en = ie; issue_idx = ii;
    rd_idx = {r1, r0};
  endtask

  task automatic drive_c(input logic we, input logic [IC-1:0] wi, input logic [XC-1:0] wd,
                         input logic ie, input logic [IC-1:0] ii,
                         input logic [IC-1:0] r0, input logic [IC-1:0] r1, input logic [IC-1:0] r2);
    wr_en_c = we; wr_idx_c = wi; wr_data_c = wd; issue_en_c = ie; issue_idx_c = ii;
    rd_idx_c = {r2, r1, r0};
  endtask

  initial begin
    drive_a(0, 0, 0, 0, 0, 0, 0);
    drive_c(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    push_exp("rst_data_a", 64'd0);  pop_check(64'(rd_data_a));
    push_exp("rst_busy_a", 64'd0);  pop_check(64'(busy_vec_a));
    push_exp("rst_data_c0", 64'd0); pop_check(rd_data_c[0 +: XC]);

    @(negedge clk); rst_n = 1'b1;

    // r5: simultaneous write and issue -> value stored and busy set
    @(negedge clk); drive_a(1, 5, 32'hDEADBEEF, 1, 5, 5, 0);
    push_exp("byp_r5_a", 64'hDEADBEEF); push_exp("byp_r5_busy_a", 64'd0);
    push_exp("nobyp_r5_b", 64'd0);
    #1; pop_check(64'(rd_data_a[0 +: XA])); pop_check(64'(rd_busy_a[0]));
    pop_check(64'(rd_data_b[0 +: XA]));
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 5, 0);
    push_exp("r5_data_a", 64'hDEADBEEF); push_exp("r5_rdbusy_a", 64'd1);
    push_exp("r5_busyvec_a", 64'h20);    push_exp("r5_data_b", 64'hDEADBEEF);
    #1; pop_check(64'(rd_data_a[0 +: XA])); pop_check(64'(rd_busy_a[0]));
    pop_check(64'(busy_vec_a)); pop_check(64'(rd_data_b[0 +: XA]));

    // asynchronous reset mid-cycle
    #1; rst_n = 1'b0;
    push_exp("arst_data_a", 64'd0); push_exp("arst_busyvec_a", 64'd0);
    push_exp("arst_rdbusy_a", 64'd0);
    #1; pop_check(64'(rd_data_a[0 +: XA])); pop_check(64'(busy_vec_a));
    pop_check(64'(rd_busy_a[0]));
    @(negedge clk); rst_n = 1'b1;

    // zero register
    @(negedge clk); drive_a(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    push_exp("r0_byp_a", 64'd0);
    #1; pop_check(64'(rd_data_a[0 +: XA]));
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 0);
    push_exp("r0_data_a", 64'd0); push_exp("r0_busyvec_a", 64'd0);
    #1; pop_check(64'(rd_data_a[0 +: XA])); pop_check(64'(busy_vec_a));

    // r7: issue+write, then bypassed overwrite
    @(negedge clk); drive_a(1, 7, 32'hAAAA5555, 1, 7, 0, 7);
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 7);
    push_exp("r7_busyvec_a", 64'h80); push_exp("r7_data_a", 64'hAAAA5555);
    push_exp("r7_rdbusy_a", 64'd1);
    #1; pop_check(64'(busy_vec_a)); pop_check(64'(rd_data_a[XA +: XA]));
    pop_check(64'(rd_busy_a[1]));
    @(negedge clk); drive_a(1, 7, 32'h12345678, 0, 0, 0, 7);
    push_exp("byp7_data_a", 64'h12345678); push_exp("byp7_rdbusy_a", 64'd0);
    push_exp("nobyp7_data_b", 64'hAAAA5555); push_exp("nobyp7_rdbusy_b", 64'd1);
    #1; pop_check(64'(rd_data_a[XA +: XA])); pop_check(64'(rd_busy_a[1]));
    pop_check(64'(rd_data_b[XA +: XA])); pop_check(64'(rd_busy_b[1]));
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 0, 7);
    push_exp("r7_clr_busyvec_a", 64'd0); push_exp("nobyp7_next_b", 64'h12345678);
    #1; pop_check(64'(busy_vec_a)); pop_check(64'(rd_data_b[XA +: XA]));

    // r3: issue, re-issue, single write clears
    @(negedge clk); drive_a(0, 0, 0, 1, 3, 3, 3);
    push_exp("r3_pre_busyvec_a", 64'd0);
    #1; pop_check(64'(busy_vec_a));
    @(negedge clk); drive_a(0, 0, 0, 1, 3, 3, 3);
    push_exp("r3_busyvec_a", 64'h8); push_exp("r3_rdbusy_a", 64'd3);
    #1; pop_check(64'(busy_vec_a)); pop_check(64'(rd_busy_a));
    @(negedge clk); drive_a(1, 3, 32'h33, 0, 0, 3, 3);
    @(negedge clk); drive_a(0, 0, 0, 0, 0, 3, 3);
    push_exp("r3_clr_busyvec_a", 64'd0); push_exp("r3_both_ports_a", {32'h33, 32'h33});
    #1; pop_check(64'(busy_vec_a)); pop_check(64'(rd_data_a));

    // wide instance: r23 on all ports, then out-of-range index 30
    @(negedge clk); drive_c(1, 23, 64'h0123456789ABCDEF, 0, 0, 23, 23, 23);
    @(negedge clk); drive_c(0, 0, 0, 0, 0, 23, 23, 23);
    push_exp("c_p0", 64'h0123456789ABCDEF); push_exp("c_p1", 64'h0123456789ABCDEF);
    push_exp("c_p2", 64'h0123456789ABCDEF);
    #1; pop_check(rd_data_c[0 +: XC]); pop_check(rd_data_c[XC +: XC]);
    pop_check(rd_data_c[2*XC +: XC]);
    @(negedge clk); drive_c(1, 30, 64'hFFFF_FFFF_FFFF_FFFF, 1, 30, 30, 23, 0);
    push_exp("c_oob_byp", 64'd0);
    #1; pop_check(rd_data_c[0 +: XC]);
    @(negedge clk); drive_c(0, 0, 0, 0, 0, 30, 23, 0);
    push_exp("c_oob_data", 64'd0); push_exp("c_oob_busyvec", 64'd0);
    push_exp("c_oob_rdbusy", 64'd0); push_exp("c_r23_kept", 64'h0123456789ABCDEF);
    #1; pop_check(rd_data_c[0 +: XC]); pop_check(64'(busy_vec_c));
    pop_check(64'(rd_busy_c)); pop_check(rd_data_c[XC +: XC]);

    if (sb.size() != 0) check_eq("sb_leftover", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
